// File: rtl/mem_port_arbiter.sv
// N-master to 1-slave memory arbiter, fixed-priority or round-robin, with optional slave timeout.
// Latency: grant in IDLE, slave request next cycle, completion same cycle as slv_ready_i; masters wait on m_ready_o.
module mem_port_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PORTS-1:0]             m_valid_i,
  input  logic [N_PORTS*ADDR_W-1:0]      m_addr_i,
  input  logic [N_PORTS*DATA_W-1:0]      m_wdata_i,
  input  logic [N_PORTS*DATA_W/8-1:0]    m_we_i,
  output logic [N_PORTS-1:0]             m_ready_o,
  output logic [N_PORTS-1:0]             m_err_o,
  output logic [DATA_W-1:0]              m_rdata_o,
  output logic                           slv_valid_o,
  input  logic                           slv_ready_i,
  output logic [ADDR_W-1:0]              slv_addr_o,
  output logic [DATA_W-1:0]              slv_wdata_o,
  output logic [DATA_W/8-1:0]            slv_we_o,
  input  logic [DATA_W-1:0]              slv_rdata_i,
  output logic                           busy_o,
  output logic [$clog2(N_PORTS)-1:0]     grant_o
);

  localparam int GW    = $clog2(N_PORTS);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [GW-1:0]      grant;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      base;
  logic [GW-1:0]      pick;
  logic [GW-1:0]      grant_inc;
  logic [CNT_W-1:0]   wait_cnt;
  logic               busy;
  logic               sel_valid;
  logic               timeout_hit;
  logic               done;
  logic [N_PORTS-1:0] grant_oh;

  // Scan downward from base+N-1 so the last hit is the first requester at or after base.
  always_comb begin
    base = (RR_MODE != 0) ? rr_ptr : '0;
    pick = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (m_valid_i[(int'(base) + i) % N_PORTS])
        pick = GW'((int'(base) + i) % N_PORTS);
    end
  end

  always_comb begin
    busy        = (state == BUSY);
    sel_valid   = m_valid_i[grant];
    timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);
    done        = busy && sel_valid && (slv_ready_i || timeout_hit);
    grant_oh    = N_PORTS'(1) << grant;
    grant_inc   = (grant == GW'(N_PORTS - 1)) ? '0 : grant + GW'(1);
  end

  // A response arriving on the timeout cycle counts as a normal completion.
  assign m_ready_o   = done ? grant_oh : '0;
  assign m_err_o     = (done && !slv_ready_i) ? grant_oh : '0;
  assign m_rdata_o   = slv_rdata_i;
  assign slv_valid_o = busy;
  assign slv_addr_o  = busy ? m_addr_i[grant*ADDR_W +: ADDR_W] : '0;
  assign slv_wdata_o = busy ? m_wdata_i[grant*DATA_W +: DATA_W] : '0;
  assign slv_we_o    = busy ? m_we_i[grant*BE_W +: BE_W] : '0;
  assign busy_o      = busy;
  assign grant_o     = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (|m_valid_i) begin
            grant <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!sel_valid) begin
            // Master withdrew its request: drop it silently, fairness pointer untouched.
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (slv_ready_i || timeout_hit) begin
            state    <= IDLE;
            rr_ptr   <= grant_inc;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 2-port fixed-priority arbiter with timeout and a 3-port round-robin arbiter.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: N_PORTS=2, fixed priority, TIMEOUT=4
  logic [1:0]  a_valid;
  logic [63:0] a_addr;
  logic [63:0] a_wdata;
  logic [7:0]  a_we;
  logic [1:0]  a_ready;
  logic [1:0]  a_err;
  logic [31:0] a_rdata;
  logic        a_svalid;
  logic        a_sready;
  logic [31:0] a_saddr;
  logic [31:0] a_swdata;
  logic [3:0]  a_swe;
  logic [31:0] a_srdata;
  logic        a_busy;
  logic [0:0]  a_grant;

  // Instance B: N_PORTS=3, round-robin, no timeout
  logic [2:0]  b_valid;
  logic [95:0] b_addr;
  logic [95:0] b_wdata;
  logic [11:0] b_we;
  logic [2:0]  b_ready;
  logic [2:0]  b_err;
  logic [31:0] b_rdata;
  logic        b_svalid;
  logic        b_sready;
  logic [31:0] b_saddr;
  logic [31:0] b_swdata;
  logic [3:0]  b_swe;
  logic [31:0] b_srdata;
  logic        b_busy;
  logic [1:0]  b_grant;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst),
    .m_valid_i(a_valid), .m_addr_i(a_addr), .m_wdata_i(a_wdata), .m_we_i(a_we),
    .m_ready_o(a_ready), .m_err_o(a_err), .m_rdata_o(a_rdata),
    .slv_valid_o(a_svalid), .slv_ready_i(a_sready), .slv_addr_o(a_saddr),
    .slv_wdata_o(a_swdata), .slv_we_o(a_swe), .slv_rdata_i(a_srdata),
    .busy_o(a_busy), .grant_o(a_grant)
  );

  mem_port_arbiter #(.N_PORTS(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .m_valid_i(b_valid), .m_addr_i(b_addr), .m_wdata_i(b_wdata), .m_we_i(b_we),
    .m_ready_o(b_ready), .m_err_o(b_err), .m_rdata_o(b_rdata),
    .slv_valid_o(b_svalid), .slv_ready_i(b_sready), .slv_addr_o(b_saddr),
    .slv_wdata_o(b_swdata), .slv_we_o(b_swe), .slv_rdata_i(b_srdata),
    .busy_o(b_busy), .grant_o(b_grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] rr_exp [4];
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd0;

    rst = 1'b1;
    a_valid = '0; a_addr = '0; a_wdata = '0; a_we = '0; a_sready = 1'b0; a_srdata = '0;
    b_valid = '0; b_addr = '0; b_wdata = '0; b_we = '0; b_sready = 1'b0; b_srdata = '0;

    // Reset state
    smp();
    chk("rst_a_busy",   a_busy,   1'b0);
    chk("rst_a_svalid", a_svalid, 1'b0);
    chk("rst_a_ready",  a_ready,  2'b00);
    chk("rst_a_err",    a_err,    2'b00);
    chk("rst_a_grant",  a_grant,  1'b0);
    chk("rst_a_swe",    a_swe,    4'h0);
    chk("rst_b_busy",   b_busy,   1'b0);
    chk("rst_b_grant",  b_grant,  2'd0);
    nxt();
    rst = 1'b0;

    // Single read from master 1, slave answers on the third BUSY cycle
    a_valid = 2'b10; a_addr[63:32] = 32'h100; a_we = '0;
    smp();
    chk("rd_idle_svalid", a_svalid, 1'b0);
    nxt();
    smp();
    chk("rd_c1_svalid", a_svalid, 1'b1);
    chk("rd_c1_addr",   a_saddr,  32'h100);
    chk("rd_c1_grant",  a_grant,  1'b1);
    chk("rd_c1_ready",  a_ready,  2'b00);
    nxt();
    smp();
    chk("rd_c2_ready", a_ready, 2'b00);
    nxt();
    a_sready = 1'b1; a_srdata = 32'hDEADBEEF;
    smp();
    chk("rd_c3_ready", a_ready, 2'b10);
    chk("rd_c3_rdata", a_rdata, 32'hDEADBEEF);
    chk("rd_c3_err",   a_err,   2'b00);
    nxt();
    a_valid = 2'b00; a_sready = 1'b0;
    smp();
    chk("rd_c4_busy", a_busy, 1'b0);

    // Fixed priority: master 1 starves while master 0 keeps requesting
    nxt();
    a_valid = 2'b11; a_sready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      smp();
      chk("fp_idle_busy", a_busy, 1'b0);
      nxt();
      smp();
      chk("fp_ready", a_ready, 2'b01);
      chk("fp_grant", a_grant, 1'b0);
      nxt();
    end
    a_valid = 2'b00; a_sready = 1'b0;

    // Byte-enabled write from master 0; enables gated by slv_valid_o
    a_valid = 2'b01; a_addr[31:0] = 32'h20; a_wdata[31:0] = 32'h12345678; a_we[3:0] = 4'b0011;
    smp();
    chk("wr_idle_swe", a_swe, 4'h0);
    nxt();
    smp();
    chk("wr_busy_swe",   a_swe,    4'b0011);
    chk("wr_busy_wdata", a_swdata, 32'h12345678);
    chk("wr_busy_addr",  a_saddr,  32'h20);
    nxt();
    a_sready = 1'b1;
    smp();
    chk("wr_done_ready", a_ready, 2'b01);
    chk("wr_done_swe",   a_swe,   4'b0011);
    nxt();
    a_valid = 2'b00; a_sready = 1'b0;
    smp();
    chk("wr_after_swe", a_swe, 4'h0);
    a_we = '0;

    // Timeout: slave silent, error on the 4th BUSY cycle
    nxt();
    a_valid = 2'b01;
    smp();
    for (int b = 1; b <= 3; b++) begin
      nxt();
      smp();
      chk("to_wait_ready", a_ready, 2'b00);
      chk("to_wait_err",   a_err,   2'b00);
    end
    nxt();
    smp();
    chk("to_ready", a_ready, 2'b01);
    chk("to_err",   a_err,   2'b01);
    nxt();
    a_valid = 2'b00;
    smp();
    chk("to_after_busy", a_busy, 1'b0);

    // Response on the timeout cycle wins over the error
    nxt();
    a_valid = 2'b01;
    smp();
    for (int b = 1; b <= 3; b++) begin
      nxt();
      smp();
    end
    nxt();
    a_sready = 1'b1;
    smp();
    chk("to_race_ready", a_ready, 2'b01);
    chk("to_race_err",   a_err,   2'b00);
    nxt();
    a_valid = 2'b00; a_sready = 1'b0;

    // Master 1 withdraws mid-transaction: no pulse, back to IDLE
    nxt();
    a_valid = 2'b10;
    nxt();
    smp();
    chk("ab_busy_grant", a_grant, 1'b1);
    nxt();
    a_valid = 2'b00;
    smp();
    chk("ab_ready", a_ready, 2'b00);
    chk("ab_err",   a_err,   2'b00);
    nxt();
    smp();
    chk("ab_after_busy", a_busy, 1'b0);

    // Round-robin over three continuously requesting masters
    nxt();
    b_valid = 3'b111; b_sready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("rr_idle_busy", b_busy, 1'b0);
      nxt();
      smp();
      chk("rr_grant", b_grant, rr_exp[k]);
      chk("rr_ready", b_ready, 3'b001 << rr_exp[k]);
      nxt();
    end

    // Reset during BUSY, then arbitration restarts from port 0
    b_sready = 1'b0;
    smp();
    nxt();
    smp();
    chk("rb_busy",  b_busy,  1'b1);
    chk("rb_grant", b_grant, 2'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rb_async_svalid", b_svalid, 1'b0);
    chk("rb_async_grant",  b_grant,  2'd0);
    nxt();
    rst = 1'b0;
    smp();
    chk("rb_idle_busy", b_busy, 1'b0);
    nxt();
    smp();
    chk("rb_first_grant", b_grant, 2'd0);
    chk("rb_first_busy",  b_busy,  1'b1);
    nxt();
    b_valid = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
